// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state, RV32I instruction formats, queue entry.
package instr_fetch_unit_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, FAULT} fetchState_t;

  typedef struct packed {
    logic [24:0] payload;
    logic [6:0]  opcode;
  } instruction_generic_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_r_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } instruction_i_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } instruction_s_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } instruction_u_t;

  typedef struct packed {
    instruction_generic_t  instr;
    logic [XLEN-1:0]       pc;
  } fetchEntry_t;

  function automatic logic [6:0] instr_opcode(input instruction_generic_t i);
    return i.opcode;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous in-order FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rstN)
    !(push && count == (AW+1)'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, pending-PC and instruction queues.
// FETCH_MISALIGN_CHECK_EN adds the FAULT state and the fetchMisaligned port.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rstN,
  output logic                 imemReqValid,
  input  logic                 imemReqReady,
  output logic [XLEN-1:0]      imemReqAddr,
  input  logic                 imemRspValid,
  input  logic [31:0]          imemRspData,
  input  logic                 redirectValid,
  input  logic [XLEN-1:0]      redirectPc,
  output logic                 instrValid,
  input  logic                 instrReady,
  output instruction_generic_t instr,
  output logic [XLEN-1:0]      instrPc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                 fetchMisaligned
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetchState_t     state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   iq_count;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credit_use;
  logic            req_fire;
  logic            pop;
  logic            redirect_act;
  logic            iq_push;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pend_head;
  fetchEntry_t     iq_wdata;
  fetchEntry_t     iq_head;

  assign pop          = instrValid & instrReady;
  assign instrValid   = iq_count != '0;
  assign instr        = iq_head.instr;
  assign instrPc      = iq_head.pc;
  assign imemReqAddr  = pc;
  // Every in-flight request (stale or not) plus every queued word holds one slot.
  assign credit_use   = {1'b0, outstanding} + {1'b0, iq_count} - (CW+1)'(pop);
  assign imemReqValid = (state == RUN) && (credit_use < (CW+1)'(FIFO_DEPTH));
  assign req_fire     = imemReqValid & imemReqReady;
  assign redirect_act = redirectValid && (state != BOOT);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned      = redirectPc[1:0] != 2'b00;
  assign redirect_tgt    = redirectPc;
  assign fetchMisaligned = state == FAULT;
`else
  assign redirect_tgt    = redirectPc & ~XLEN'(3);
`endif

  // Responses in the redirect cycle and while draining stale requests are dropped.
  assign iq_push  = imemRspValid && (drop_cnt == '0) && !redirect_act;
  assign iq_wdata = '{instr: instruction_generic_t'(imemRspData), pc: pend_head};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      case (state)
        BOOT:  state <= RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
        RUN:   if (redirect_act && misaligned) state <= FAULT;
        FAULT: if (redirect_act && !misaligned) state <= RUN;
`endif
        default: state <= RUN;
      endcase

      if (redirect_act)  pc <= redirect_tgt;
      else if (req_fire) pc <= pc + XLEN'(4);

      if (redirect_act)
        drop_cnt <= outstanding + CW'(req_fire) - CW'(imemRspValid);
      else if (imemRspValid && drop_cnt != '0)
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pend_q (
    .clk   (clk),
    .rstN  (rstN),
    .push  (req_fire),
    .wdata (pc),
    .pop   (imemRspValid),
    .flush (1'b0),
    .head  (pend_head),
    .count (outstanding)
  );

  fetch_fifo #(.WIDTH($bits(fetchEntry_t)), .DEPTH(FIFO_DEPTH)) u_instr_q (
    .clk   (clk),
    .rstN  (rstN),
    .push  (iq_push),
    .wdata (iq_wdata),
    .pop   (pop),
    .flush (redirect_act),
    .head  (iq_head),
    .count (iq_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven fill check, directed corners, random run
// against an in-order memory model and a sequential-PC stream scoreboard.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rstN = 1'b0;
  logic                 imem_req_valid;
  logic                 imem_req_ready = 1'b0;
  logic [31:0]          imem_req_addr;
  logic                 imem_rsp_valid = 1'b0;
  logic [31:0]          imem_rsp_data = 32'h0;
  logic                 redirect_valid = 1'b0;
  logic [31:0]          redirect_pc = 32'h0;
  logic                 instr_valid;
  logic                 instr_ready = 1'b0;
  instruction_generic_t instr;
  logic [31:0]          instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                 fetch_misaligned;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC_DEFAULT), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .imemReqValid  (imem_req_valid),
    .imemReqReady  (imem_req_ready),
    .imemReqAddr   (imem_req_addr),
    .imemRspValid  (imem_rsp_valid),
    .imemRspData   (imem_rsp_data),
    .redirectValid (redirect_valid),
    .redirectPc    (redirect_pc),
    .instrValid    (instr_valid),
    .instrReady    (instr_ready),
    .instr         (instr),
    .instrPc       (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetchMisaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        iready;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  vec_t        tbl[6];
  mreq_t       memq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fire_cnt = 0;
  int          pop_cnt = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        k_rstn = 1'b0;
  logic        k_ready = 1'b0;
  logic        k_iready = 1'b0;
  logic        k_redir = 1'b0;
  logic [31:0] k_target = 32'h0;
  logic        s_rv, s_iv, s_fire, s_pop, s_rsp;
  logic [31:0] s_addr, s_pc, s_instr;
  logic        s_mis = 1'b0;
  logic [31:0] exp_req_pc = RESET_PC_DEFAULT;
  logic [31:0] exp_dec_pc = RESET_PC_DEFAULT;
  logic [31:0] last_pop_pc = 32'h0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  // Distinct word per address: rotate then xor.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, sample #1 later, update model and scoreboard.
  task automatic step();
    @(negedge clk);
    rstN           = k_rstn;
    imem_req_ready = k_ready;
    instr_ready    = k_iready;
    redirect_valid = k_redir;
    redirect_pc    = k_target;
    if (k_rstn && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    s_rv    = imem_req_valid;
    s_addr  = imem_req_addr;
    s_iv    = instr_valid;
    s_pc    = instr_pc;
    s_instr = instr;
    s_rsp   = imem_rsp_valid;
    s_fire  = s_rv & imem_req_ready;
    s_pop   = s_iv & instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    s_mis   = fetch_misaligned;
`endif
    if (!k_rstn) begin
      memq.delete();
      exp_req_pc = RESET_PC_DEFAULT;
      exp_dec_pc = RESET_PC_DEFAULT;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(s_rv), 32'd1);
        chk("hold_addr", s_addr, prev_addr);
      end
      if (s_rsp) void'(memq.pop_front());
      if (s_fire) begin
        chk("req_addr", s_addr, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
        fire_cnt++;
        memq.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        chk("inflight_cap", 32'(memq.size() <= DEPTH), 32'd1);
      end
      if (s_pop) begin
        chk("dec_pc", s_pc, exp_dec_pc);
        chk("dec_word", s_instr, mem_word(exp_dec_pc));
        exp_dec_pc  = exp_dec_pc + 32'd4;
        last_pop_pc = s_pc;
        pop_cnt++;
      end
      if (k_redir) begin
        exp_req_pc = eff_target(k_target);
        exp_dec_pc = eff_target(k_target);
      end
      prev_hold = s_rv && !imem_req_ready && !k_redir;
      prev_addr = s_addr;
    end
    cyc++;
    k_redir = 1'b0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp);
    int start;
    int n;
    start = pop_cnt;
    n = 0;
    while (pop_cnt == start && n < 40) begin
      step();
      n++;
    end
    if (pop_cnt == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no instruction delivered within 40 cycles, expected pc %h", name, exp);
    end else begin
      chk(name, last_pop_pc, exp);
    end
  endtask

  task automatic reset_dut();
    k_rstn = 1'b0;
    k_redir = 1'b0;
    step();
    step();
    k_rstn = 1'b1;
  endtask

  initial begin
    int f0;
    int p0;
    logic [31:0] a0;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};

    // Reset values
    k_rstn = 1'b0;
    step();
    step();
    chk("rst_req_valid", 32'(s_rv), 32'd0);
    chk("rst_req_addr", s_addr, RESET_PC_DEFAULT);
    chk("rst_instr_valid", 32'(s_iv), 32'd0);
    chk("rst_instr", s_instr, 32'h0);
    chk("rst_instr_pc", s_pc, 32'h0);
    chk("rst_misaligned", 32'(s_mis), 32'd0);

    // Fill sequence, 1-cycle memory, decode always ready
    lat_min = 1; lat_max = 1;
    k_rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      k_ready  = tbl[i].ready;
      k_iready = tbl[i].iready;
      step();
      chk("fill_req_valid", 32'(s_rv), 32'(tbl[i].rv));
      if (tbl[i].rv) chk("fill_req_addr", s_addr, tbl[i].addr);
      chk("fill_instr_valid", 32'(s_iv), 32'(tbl[i].iv));
      if (tbl[i].iv) begin
        chk("fill_instr_pc", s_pc, tbl[i].pc);
        chk("fill_instr_word", s_instr, mem_word(tbl[i].pc));
      end
    end

    // Redirect coincident with a response and an accepted request
    k_redir = 1'b1; k_target = 32'h300;
    step();
    chk("coinc_rsp", 32'(s_rsp), 32'd1);
    chk("coinc_fire", 32'(s_fire), 32'd1);
    wait_pop("coinc_first_pc", 32'h300);
    wait_pop("coinc_second_pc", 32'h304);

    // Memory not ready for 5 cycles: address held, PC frozen
    k_ready = 1'b0;
    step();
    a0 = s_addr;
    f0 = fire_cnt;
    chk("stall_valid0", 32'(s_rv), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", s_addr, a0);
    end
    chk("stall_no_fire", 32'(fire_cnt - f0), 32'd0);
    k_ready = 1'b1;
    step();
    chk("stall_release_fire", 32'(s_fire), 32'd1);
    chk("stall_release_addr", s_addr, a0);

    // Decode stalled: exactly FIFO_DEPTH requests, then resume at 0x8
    reset_dut();
    k_ready = 1'b1; k_iready = 1'b0;
    f0 = fire_cnt;
    for (int i = 0; i < 10; i++) step();
    chk("bp_fires", 32'(fire_cnt - f0), 32'd2);
    chk("bp_req_valid", 32'(s_rv), 32'd0);
    chk("bp_instr_valid", 32'(s_iv), 32'd1);
    chk("bp_head_pc", s_pc, 32'h0);
    k_iready = 1'b1;
    step();
    chk("bp_pop0", s_pc, 32'h0);
    chk("bp_resume_fire", 32'(s_fire), 32'd1);
    chk("bp_resume_addr", s_addr, 32'h8);
    step();
    chk("bp_pop1", s_pc, 32'h4);

    // Redirect with two responses in flight (latency 3)
    reset_dut();
    lat_min = 3; lat_max = 3;
    k_ready = 1'b1; k_iready = 1'b1;
    step(); step(); step();
    chk("lat3_inflight", 32'(memq.size()), 32'd2);
    k_redir = 1'b1; k_target = 32'h100;
    step();
    wait_pop("lat3_first_pc", 32'h100);
    wait_pop("lat3_second_pc", 32'h104);

    // Misaligned redirect
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step();
    k_redir = 1'b1; k_target = 32'h102;
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    f0 = fire_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fault_flag", 32'(s_mis), 32'd1);
    end
    chk("fault_no_req", 32'(fire_cnt - f0), 32'd0);
    k_redir = 1'b1; k_target = 32'h200;
    step();
    step();
    chk("fault_cleared", 32'(s_mis), 32'd0);
    chk("fault_resume_fire", 32'(s_fire), 32'd1);
    chk("fault_resume_addr", s_addr, 32'h200);
    wait_pop("fault_first_pc", 32'h200);
`else
    wait_pop("align_forced_pc", 32'h100);
`endif

    // Wrap of the PC past 2^32
    k_redir = 1'b1; k_target = 32'hFFFF_FFF8;
    step();
    wait_pop("wrap_pc0", 32'hFFFF_FFF8);
    wait_pop("wrap_pc1", 32'hFFFF_FFFC);
    wait_pop("wrap_pc2", 32'h0000_0000);

    // Random traffic with a mid-run reset
    reset_dut();
    lat_min = 1; lat_max = 4;
    p0 = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      k_rstn   = !(i == 1500 || i == 1501);
      k_ready  = $urandom_range(0, 3) != 0;
      k_iready = $urandom_range(0, 3) != 0;
      k_redir  = (i > 2) && (i < 1500 || i > 1503) && ($urandom_range(0, 29) == 0);
      k_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      step();
    end
    chk("rand_progress", 32'(pop_cnt - p0 > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RV32I core. It owns the program counter and issues word-aligned fetch requests to instruction memory over a valid/ready handshake. It buffers returned instruction words, each tagged with its PC, in a small in-order queue, and presents them to the decode stage, which splits them into R/I/S/U formats using the shared package types. Branch and jump redirects from execute flush the queue and discard responses still in flight.

## Interface
- XLEN, 32, datapath width (from shared package)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, instruction queue depth; also the cap on in-flight requests (power of 2, ≥2)
- clk  in  1  clock, rising edge
- rstN  in  1  asynchronous active-low reset
- imemReqValid  out  1  fetch request valid
- imemReqReady  in  1  memory accepts request
- imemReqAddr  out  XLEN  fetch address (PC)
- imemRspValid  in  1  response word valid; in order, ≥1 cycle after acceptance, no backpressure
- imemRspData  in  32  instruction word
- redirectValid  in  1  control-flow redirect from execute (single-cycle pulse)
- redirectPc  in  XLEN  redirect target
- instrValid  out  1  instruction available to decode
- instrReady  in  1  decode consumes instruction
- instr  out  32  instruction word (instruction_generic_t)
- instrPc  out  XLEN  PC of instr
- fetchMisaligned  out  1  misaligned-target fault (FETCH_MISALIGN_CHECK_EN only)

## Operation
- FSM states: BOOT (first cycle after reset release; no request), RUN, FAULT (FAULT exists only with the macro).
- Transitions: BOOT→RUN unconditionally. RUN→FAULT on a redirect with redirectPc[1:0]≠0. FAULT→RUN on an aligned redirect.
- Request rule in RUN: imemReqValid = (outstanding + count − pop) < FIFO_DEPTH. Here pop = instrValid & instrReady, and count is the number of queue entries.
- On reqFire, the PC advances by 4 (wraps modulo 2^XLEN) and is pushed into a pending-PC queue.
- On imemRspValid, the head pending PC is popped. If dropCount > 0, the word is discarded and dropCount decrements. Otherwise {word, PC} is written into the instruction queue.
- Redirect, in RUN or FAULT:
  - Instruction queue is cleared.
  - PC ← redirectPc.
  - dropCount ← outstanding + reqFire − imemRspValid.
  - A response arriving in the redirect cycle is discarded.
  - A request accepted in the redirect cycle (old PC) counts as stale.
- Pending-PC entries for stale requests are still popped as their responses return.
- Redirect takes priority over same-cycle push and pop. A pop in the redirect cycle is still a valid handoff to decode.
- Queue overflow cannot occur by construction. Assertion: no push when count == FIFO_DEPTH.
- instrValid = count ≠ 0; instr/instrPc = queue head.

## Timing
- Reset values: imemReqValid=0, imemReqAddr=RESET_PC, instrValid=0, instr=0, instrPc=0, fetchMisaligned=0, outstanding=0, dropCount=0, state=BOOT.
- First request: imemReqValid=1 at the first cycle after BOOT, address RESET_PC.
- Response cycle N → instrValid at N+1 (registered queue, no bypass).
- Redirect at cycle N → imemReqAddr=redirectPc with imemReqValid=1 at N+1, subject to credit.
- With 1-cycle memory latency and instrReady held high: throughput is 1 instr/cycle after a 3-cycle fill.
- imemReqAddr stays stable while imemReqValid=1 and imemReqReady=0.
- Reset mid-operation: all state clears immediately. Memory must also drop in-flight responses on reset.

## Configuration
- FETCH_MISALIGN_CHECK_EN
  - Defined: a redirect with redirectPc[1:0]≠0 enters FAULT. In FAULT, fetchMisaligned=1 and no requests issue; the queue is already flushed and stale responses are still dropped.
  - Undefined: no FAULT state and no port. redirectPc[1:0] is forced to 00.

## Structure
- Shared package additions:
  - fetchState_t enum (BOOT, RUN, FAULT)
  - fetchEntry_t packed struct {instruction_generic_t instr; logic [XLEN-1:0] pc}
  - RESET_PC default constant
- One sub-module, fetch_fifo: synchronous FIFO, parameterised on width and depth, with push/pop/flush and count output. It is instantiated twice, once for the pending-PC queue and once for the instruction queue.

## Test plan
- Reset release, memory always ready with 1-cycle latency, instrReady=1 → addresses 0x0, 0x4, 0x8… issued back-to-back. Decode sees the PC/word pairs in order, one per cycle, from the 4th cycle.
- instrReady=0 for 10 cycles → exactly FIFO_DEPTH=2 requests accepted, then imemReqValid=0 and the queue holds 0x0 and 0x4. Releasing instrReady resumes issue at 0x8.
- Redirect to 0x100 with 2 responses in flight (memory latency 3) → both stale words dropped. First decoded instruction has instrPc=0x100, then 0x104.
- Redirect coincident with response and request acceptance → that response is dropped and the accepted request counts as stale. The next instruction delivered has instrPc=redirectPc.
- imemReqReady low for 5 cycles → imemReqAddr held at its value throughout; PC does not advance.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → fetchMisaligned=1 and no requests. A redirect to 0x200 then clears the fault and the next request is at 0x200.
